// File: rtl/memory_slave_bram.sv
`default_nettype none
// ============================================================================
// Module   : memory_slave_bram
// Purpose  : Block-RAM-backed target on the memory bus. Accepts address/data/ID
//            requests on the ms* channel, performs the BRAM write or read, and
//            returns read data (and optionally write acks) tagged with the
//            request ID on the sm* channel, in acceptance order, through a
//            small response FIFO.
// Ports    : clock, reset           - clock, synchronous active-high reset
//            msValid/msTaken        - request handshake
//            msAddress/msData/msID  - word address, write data, request tag
//            msWrite                - 1 = write, 0 = read
//            smValid/smTaken        - response handshake
//            smData/smID            - read data (0 for write acks), tag
// Options  : MEMORY_SLAVE_WRITE_ACK_EN - when defined, every accepted write
//            (hit or miss) produces a {24'h0, ID} response and uses a credit.
// Revision : 1.0 - initial release
// ============================================================================
module memory_slave_bram #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        msValid,
    output logic        msTaken,
    input  logic [31:0] msAddress,
    input  logic [23:0] msData,
    input  logic [7:0]  msID,
    input  logic        msWrite,
    output logic        smValid,
    input  logic        smTaken,
    output logic [23:0] smData,
    output logic [7:0]  smID
);

    localparam int unsigned c_PTR_W  = $clog2(RESP_DEPTH);
    localparam int unsigned c_CNT_W  = c_PTR_W + 1;
    localparam int unsigned c_PEND_W = c_PTR_W + 2;
    localparam int unsigned c_WORDS  = 1 << DEPTH_LOG2;

`ifdef MEMORY_SLAVE_WRITE_ACK_EN
    localparam logic c_WRITE_ACK = 1'b1;
`else
    localparam logic c_WRITE_ACK = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [23:0]           mem_q [0:c_WORDS-1];
    logic [23:0]           bram_dout_q;

    logic                  s1_valid_q;
    logic                  s1_write_q;
    logic                  s1_hit_q;
    logic [DEPTH_LOG2-1:0] s1_index_q;
    logic [7:0]            s1_id_q;

    logic                  s2_valid_q;
    logic                  s2_write_q;
    logic                  s2_hit_q;
    logic [7:0]            s2_id_q;

    logic [23:0]           fifo_data_q [0:RESP_DEPTH-1];
    logic [7:0]            fifo_id_q   [0:RESP_DEPTH-1];
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q,  count_d;

    // ------------------------------------------------------------------
    // Request decode and credit check
    // ------------------------------------------------------------------
    logic                  w_hit;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_accept;
    logic                  w_needs_resp;
    logic [c_PEND_W-1:0]   w_pending;

    assign w_hit        = (msAddress[31:DEPTH_LOG2] == BASE_ADDR[31:DEPTH_LOG2]);
    assign w_index      = msAddress[DEPTH_LOG2-1:0];
    assign w_needs_resp = !msWrite || c_WRITE_ACK;

    // Every response-producing request holds a credit from acceptance until
    // its response is popped, so the FIFO can never overflow.
    assign w_pending = c_PEND_W'(count_q) + c_PEND_W'(s1_valid_q) + c_PEND_W'(s2_valid_q);
    assign msTaken   = !reset && (w_pending < c_PEND_W'(RESP_DEPTH));
    assign w_accept  = msValid && msTaken;

    // ------------------------------------------------------------------
    // BRAM: write on the accept edge, registered read from the S1 index.
    // A write accepted one cycle before a read to the same index is
    // already in the array when the read's S1 looks it up.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept && msWrite && w_hit) begin
            mem_q[w_index] <= msData;
        end
        bram_dout_q <= mem_q[s1_index_q];
    end

    // ------------------------------------------------------------------
    // Read / ack pipeline (S1 -> S2 -> FIFO)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= w_accept && w_needs_resp;
            s2_valid_q <= s1_valid_q;
        end
        s1_write_q <= msWrite;
        s1_hit_q   <= w_hit;
        s1_index_q <= w_index;
        s1_id_q    <= msID;
        s2_write_q <= s1_write_q;
        s2_hit_q   <= s1_hit_q;
        s2_id_q    <= s1_id_q;
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic        w_push;
    logic        w_pop;
    logic [23:0] w_push_data;

    assign w_push      = s2_valid_q;
    assign w_push_data = (s2_hit_q && !s2_write_q) ? bram_dout_q : 24'h0;
    assign smValid     = !reset && (count_q != '0);
    assign w_pop       = smValid && smTaken;
    assign smData      = fifo_data_q[rd_ptr_q];
    assign smID        = fifo_id_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            fifo_data_q[wr_ptr_q] <= w_push_data;
            fifo_id_q[wr_ptr_q]   <= s2_id_q;
        end
    end

endmodule
`default_nettype wire
